// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the calculator datapath (adder and subtractor).
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } resta_state_t;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/resta_digito_bcd.sv
// One BCD digit of subtraction with borrow: a - b - borrow_in, wrapped into 0..9.
module resta_digito_bcd
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       borrow_in,
  output bcd_digit_t digit,
  output logic       borrow_out
);

  logic signed [4:0] w_diff;
  logic signed [4:0] w_wrapped;

  // Range of w_diff is -10..9, so adding ten always lands back in 0..9.
  always_comb begin
    w_diff    = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, borrow_in});
    w_wrapped = w_diff + 5'sd10;
    if (w_diff < 5'sd0) begin
      digit      = w_wrapped[3:0];
      borrow_out = 1'b1;
    end else begin
      digit      = w_diff[3:0];
      borrow_out = 1'b0;
    end
  end

endmodule

// File: rtl/resta_bcd_serial.sv
// Digit-serial 3-digit BCD subtractor: returns |A-B| and a sign flag, one digit per clock.
module resta_bcd_serial
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  bcd_digit_t dig1_1,
  input  bcd_digit_t dig1_2,
  input  bcd_digit_t dig1_3,
  input  bcd_digit_t dig2_1,
  input  bcd_digit_t dig2_2,
  input  bcd_digit_t dig2_3,
  output logic       busy,
  output logic       done,
  output bcd_digit_t digito1,
  output bcd_digit_t digito2,
  output bcd_digit_t digito3,
  output logic       negativo,
  output logic       error
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

  resta_state_t r_state;
  logic [11:0]  r_a;
  logic [11:0]  r_b;
  bcd_digit_t   r_res1;
  bcd_digit_t   r_res2;
  logic         r_borrow;
  logic [1:0]   r_idx;
  logic         r_neg_pend;

  logic [11:0]  w_a_in;
  logic [11:0]  w_b_in;
  logic         w_valid;
  logic         w_a_lt_b;
  bcd_digit_t   w_a_dig;
  bcd_digit_t   w_b_dig;
  bcd_digit_t   w_digit;
  logic         w_borrow_out;

  assign w_a_in   = {dig1_3, dig1_2, dig1_1};
  assign w_b_in   = {dig2_3, dig2_2, dig2_1};
  assign w_valid  = is_bcd(dig1_1) & is_bcd(dig1_2) & is_bcd(dig1_3) &
                    is_bcd(dig2_1) & is_bcd(dig2_2) & is_bcd(dig2_3);
  // Valid BCD packs hundreds-first, so a plain binary compare orders the numbers.
  assign w_a_lt_b = (w_a_in < w_b_in);

  always_comb begin
    case (r_idx)
      2'd0: begin
        w_a_dig = r_a[3:0];
        w_b_dig = r_b[3:0];
      end
      2'd1: begin
        w_a_dig = r_a[7:4];
        w_b_dig = r_b[7:4];
      end
      2'd2: begin
        w_a_dig = r_a[11:8];
        w_b_dig = r_b[11:8];
      end
      default: begin
        w_a_dig = 4'd0;
        w_b_dig = 4'd0;
      end
    endcase
  end

  resta_digito_bcd u_digito (
    .a          (w_a_dig),
    .b          (w_b_dig),
    .borrow_in  (r_borrow),
    .digit      (w_digit),
    .borrow_out (w_borrow_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= 12'd0;
      r_b        <= 12'd0;
      r_res1     <= 4'd0;
      r_res2     <= 4'd0;
      r_borrow   <= 1'b0;
      r_idx      <= 2'd0;
      r_neg_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      digito1    <= 4'd0;
      digito2    <= 4'd0;
      digito3    <= 4'd0;
      negativo   <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (!w_valid) begin
              error    <= 1'b1;
              digito1  <= 4'd0;
              digito2  <= 4'd0;
              digito3  <= 4'd0;
              negativo <= 1'b0;
              done     <= 1'b1;
              r_state  <= DONE;
            end else begin
              // Larger operand goes on top so the borrow chain never underflows.
              if (w_a_lt_b) begin
                r_a        <= w_b_in;
                r_b        <= w_a_in;
                r_neg_pend <= 1'b1;
              end else begin
                r_a        <= w_a_in;
                r_b        <= w_b_in;
                r_neg_pend <= 1'b0;
              end
              r_borrow <= 1'b0;
              r_idx    <= 2'd0;
              busy     <= 1'b1;
              r_state  <= SUB;
            end
          end
        end
        SUB: begin
          r_borrow <= w_borrow_out;
          if (r_idx == 2'd0) begin
            r_res1 <= w_digit;
          end
          if (r_idx == 2'd1) begin
            r_res2 <= w_digit;
          end
          if (r_idx == LAST_IDX) begin
            digito1  <= r_res1;
            digito2  <= r_res2;
            digito3  <= w_digit;
            negativo <= r_neg_pend;
            error    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resta_bcd_serial.sv
// Self-checking bench for resta_bcd_serial: directed cases plus randomized operands vs an arithmetic model.
module tb_resta_bcd_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dig1_1, dig1_2, dig1_3;
  logic [3:0] dig2_1, dig2_2, dig2_3;
  logic       busy, done, negativo, error;
  logic [3:0] digito1, digito2, digito3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  resta_bcd_serial dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dig1_1   (dig1_1),
    .dig1_2   (dig1_2),
    .dig1_3   (dig1_3),
    .dig2_1   (dig2_1),
    .dig2_2   (dig2_2),
    .dig2_3   (dig2_3),
    .busy     (busy),
    .done     (done),
    .digito1  (digito1),
    .digito2  (digito2),
    .digito3  (digito3),
    .negativo (negativo),
    .error    (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rand_operand(input bit allow_bad);
    logic [11:0] v;
    int n;
    n = $urandom_range(0, 999);
    v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    if (allow_bad && ($urandom_range(0, 5) == 0)) begin
      v[4 * $urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  // One request: apply operands, follow it to done, compare against |A-B| computed arithmetically.
  task automatic run_op(input logic [11:0] a, input logic [11:0] b, input bit inject);
    bit   bad;
    int   av, bv, diff, mag;
    int   e1, e2, e3, eneg, eerr, elat;
    int   cyc, busy_cnt;
    bit   got, held;
    logic [12:0] prev;

    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    av   = int'(a[11:8]) * 100 + int'(a[7:4]) * 10 + int'(a[3:0]);
    bv   = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    diff = av - bv;
    mag  = (diff < 0) ? -diff : diff;
    if (bad) begin
      e1 = 0; e2 = 0; e3 = 0; eneg = 0; eerr = 1; elat = 0;
    end else begin
      e1 = mag % 10; e2 = (mag / 10) % 10; e3 = mag / 100;
      eneg = (diff < 0) ? 1 : 0; eerr = 0; elat = 3;
    end

    @(negedge clk);
    prev   = {digito3, digito2, digito1, negativo};
    {dig1_3, dig1_2, dig1_1} = a;
    {dig2_3, dig2_2, dig2_1} = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands may change after the start edge without effect.
    {dig1_3, dig1_2, dig1_1} = rand_operand(1'b0);
    {dig2_3, dig2_2, dig2_1} = rand_operand(1'b0);

    cyc = 0; busy_cnt = 0; got = 1'b0; held = 1'b1;
    while (!got && cyc < 12) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if ({digito3, digito2, digito1, negativo} !== prev) held = 1'b0;
        if (inject && cyc == 1) begin
          {dig1_3, dig1_2, dig1_1} = rand_operand(1'b1);
          {dig2_3, dig2_2, dig2_1} = rand_operand(1'b1);
          start = 1'b1;
        end
        if (inject && cyc == 2) start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(elat));
    check("busy_cycles", 32'(busy_cnt), 32'(elat));
    check("busy_at_done", 32'(busy), 32'd0);
    check("outputs_held", 32'(held), 32'd1);
    check("digito1", 32'(digito1), 32'(e1));
    check("digito2", 32'(digito2), 32'(e2));
    check("digito3", 32'(digito3), 32'(e3));
    check("negativo", 32'(negativo), 32'(eneg));
    check("error", 32'(error), 32'(eerr));

    if (inject) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("start_in_done_ignored", 32'(busy), 32'd0);
    check("result_kept", 32'({digito3, digito2, digito1}), 32'({e3[3:0], e2[3:0], e1[3:0]}));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    {dig1_3, dig1_2, dig1_1} = 12'h000;
    {dig2_3, dig2_2, dig2_1} = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_digits", 32'({digito3, digito2, digito1}), 32'd0);
    check("rst_negativo", 32'(negativo), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(12'h523, 12'h187, 1'b0);
    run_op(12'h187, 12'h523, 1'b0);
    run_op(12'h000, 12'h999, 1'b0);
    run_op(12'h500, 12'h001, 1'b0);
    run_op(12'h456, 12'h456, 1'b0);
    run_op(12'h45B, 12'h123, 1'b0);
    run_op(12'h010, 12'h005, 1'b0);
    run_op(12'h777, 12'h123, 1'b1);
    run_op(12'h123, 12'h777, 1'b1);

    // Asynchronous reset in the middle of SUB.
    @(negedge clk);
    {dig1_3, dig1_2, dig1_1} = 12'h942;
    {dig2_3, dig2_2, dig2_1} = 12'h318;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_digits", 32'({digito3, digito2, digito1}), 32'd0);
    check("async_rst_negativo", 32'(negativo), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 32'(done), 32'd0);
    end

    run_op(12'h321, 12'h098, 1'b0);

    for (int n = 0; n < 30; n++) begin
      run_op(rand_operand(1'b1), rand_operand(1'b1), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/resta_bcd_serial.md
Name: resta_bcd_serial

Overview:
Digit-serial 3-digit BCD subtractor, the inverse operation of the existing 3-digit BCD adder in the calculator datapath.
- Accepts two 3-digit BCD operands A and B on a start strobe and returns |A-B| as 3 BCD digits plus a sign flag.
- Processes one digit per clock, least significant digit first, with a borrow chain.
- Sits between the keypad operand registers and the 7-segment display mux, alongside the adder; the operation select picks which result is displayed.

Parameters:
- None. The digit count is fixed at 3 to match the adder and display datapath; the constant lives in the shared package.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dig1_1  input  4  A units (BCD)
- dig1_2  input  4  A tens
- dig1_3  input  4  A hundreds
- dig2_1  input  4  B units
- dig2_2  input  4  B tens
- dig2_3  input  4  B hundreds
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when the result is valid
- digito1  output  4  result units
- digito2  output  4  result tens
- digito3  output  4  result hundreds
- negativo  output  1  1 when A<B (result is B-A)
- error  output  1  1 when the last request had a non-BCD input digit

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (rst).
- Reset, async and usable mid-operation:
  - state=IDLE; busy, done, negativo and error = 0; digito1..3 = 0.
  - Internal operand, borrow and index registers cleared.
  - An in-flight subtraction is abandoned and produces no done.
- FSM states are IDLE, SUB and DONE.
- IDLE:
  - start=1 at edge E0 latches all six digits.
  - If any digit >9: error<=1, result digits<=0, negativo<=0, go to DONE.
  - Otherwise compare A and B as 3-digit numbers (hundreds, then tens, then units).
    - If A<B, the operands are swapped into the working registers and negativo_pending=1.
    - borrow<=0, idx<=0, go to SUB.
- SUB, one digit per edge, idx = 0, 1, 2:
  - diff = a[idx] - b[idx] - borrow, computed in 5-bit signed.
  - If diff<0: digit = diff+10 and borrow<=1. Else digit = diff and borrow<=0.
  - The digit is written to the working result register.
  - At idx=2, go to DONE; the final borrow is always 0 because of the swap.
- DONE, lasts one cycle:
  - done=1.
  - digito1..3 and negativo update from the working registers on the edge that enters DONE.
  - Next edge goes to IDLE with done=0.
- Latency:
  - start seen at E0 gives busy=1 from E0 through E3, then done=1 in the cycle after E3 (4 cycles after start).
  - Invalid-input case: done in the cycle after E0, with busy never asserted.
- Output holding:
  - digito1..3, negativo and error hold their values until the next completed request.
  - They do not change during SUB.
- start while busy=1 or during DONE is ignored: not queued, no effect.
- Equal operands give 000 with negativo=0.
- Input digits may change after E0 without effect.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - Constants BCD_MAX=4'd9 and NUM_DIGITS=3.
  - Enum resta_state_t {IDLE, SUB, DONE}.
  - The package is shared with the adder for future cleanup.
- One combinational sub-module, resta_digito_bcd:
  - Inputs a, b, borrow_in; outputs digit and borrow_out.
  - Instantiated once and muxed by idx.

Test Plan:
- 523-187: start pulse -> done 4 cycles later, digits 3/3/6, negativo=0, error=0; busy high exactly 3 cycles.
- 187-523 -> digits 3/3/6, negativo=1. Then 000-999 -> 9/9/9, negativo=1.
- 500-001 (full borrow chain) -> 4/9/9, negativo=0. Then 456-456 -> 0/0/0, negativo=0.
- A units digit 4'hB with B=123 -> done in the cycle after start, error=1, digits 0/0/0. A following valid 010-005 clears error and gives 0/0/5.
- Second start pulse during SUB, with different operands -> ignored, and the first result is intact. A start asserted in the same cycle as done is also ignored.
- rst asserted asynchronously (between clock edges) during SUB -> outputs 0 immediately, no done. The next start after reset completes normally.
